// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the data-memory access unit.
// Addressing codes, FSM encoding and size decode.
package mem_access_pkg;

  localparam logic [1:0] WORD    = 2'b00;
  localparam logic [1:0] HALF    = 2'b01;
  localparam logic [1:0] ILLEGAL = 2'b10;
  localparam logic [1:0] BYTE    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] size
  );
    logic [2:0] n;
    n = 3'd4;
    unique case (1'b1)
      size == HALF: n = 3'd2;
      size == BYTE: n = 3'd1;
      default:      n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      size == WORD: m = (lo != 2'b00);
      size == HALF: m = lo[0];
      default:      m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between MEM stage and access unit.
// master = MEM stage side, slave = access unit side.
interface mem_access_unit_if #(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_ADDRESS  = 6
);

  logic                   i_req_valid;
  logic                   o_req_ready;
  logic                   i_req_we;
  logic [1:0]             i_req_size;
  logic                   i_req_unsigned;
  logic [NB_ADDRESS-1:0]  i_req_addr;
  logic [NB_DATA_BUS-1:0] i_req_wdata;
  logic                   o_rsp_valid;
  logic [NB_DATA_BUS-1:0] o_rsp_rdata;
  logic                   o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_size,
    output i_req_unsigned, i_req_addr, i_req_wdata,
    input  o_req_ready, o_rsp_valid,
    input  o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_size,
    input  i_req_unsigned, i_req_addr, i_req_wdata,
    output o_req_ready, o_rsp_valid,
    output o_rsp_rdata, o_rsp_err
  );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of raw load data to 32 bits.
// Pure combinational; also reused by the writeback stage.
module load_extend
  import mem_access_pkg::*;
#(
  parameter int NB_DATA = 8
) (
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  localparam int NH = 2 * NB_DATA;

  logic sb;
  logic sh;

  assign sb = ~uns & data[NB_DATA-1];
  assign sh = ~uns & data[NH-1];

  // extend by access size; words pass through
  always_comb begin
    result = data;
    unique case (1'b1)
      size == BYTE:
        result = {{(32-NB_DATA){sb}},
                  data[NB_DATA-1:0]};
      size == HALF:
        result = {{(32-NH){sh}},
                  data[NH-1:0]};
      default:
        result = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one request, one response pulse.
// Optional MEM_ACCESS_UNALIGNED_SPLIT_EN splits misaligned ops.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_DATA     = 8,
  parameter int N_ADDRESS   = 64,
  parameter int NB_ADDRESS  = $clog2(N_ADDRESS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  mem_access_unit_if.slave       bus,
  output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
  output logic                   o_mem_r_en,
  output logic [1:0]             o_mem_r_addressing,
  input  logic [NB_DATA_BUS-1:0] i_mem_r_data,
  output logic [NB_ADDRESS-1:0]  o_mem_w_addr,
  output logic [NB_DATA_BUS-1:0] o_mem_w_data,
  output logic                   o_mem_w_en,
  output logic [1:0]             o_mem_w_addressing
);

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic        acc;
  logic        bad;
  logic        mis;
  logic        last;
  logic [31:0] ld_data;
  logic [31:0] ext;

  assign bus.o_req_ready = (state == IDLE);
  assign acc = bus.i_req_valid && (state == IDLE);
  assign mis = misaligned(bus.i_req_size,
                          bus.i_req_addr[1:0]);

`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
  logic                   split_q;
  logic [1:0]             k;
  logic [1:0]             kn;
  logic [NB_ADDRESS-1:0]  addr_q;
  logic [NB_DATA_BUS-1:0] wdata_q;
  logic [31:0]            asm_q;
  logic [31:0]            asm_nx;

  assign bad = (bus.i_req_size == ILLEGAL);
  assign kn  = k + 2'd1;
  assign last = !split_q ||
    (k == 2'(size_bytes(size_q) - 3'd1));
  assign ld_data = split_q ? asm_nx : i_mem_r_data;

  // drop the current byte into its little-endian slot
  always_comb begin
    asm_nx = asm_q;
    asm_nx[{k, 3'b000} +: NB_DATA] =
      i_mem_r_data[NB_DATA-1:0];
  end
`else
  assign bad  = (bus.i_req_size == ILLEGAL) || mis;
  assign last = 1'b1;
  assign ld_data = i_mem_r_data;
`endif

  load_extend #(
    .NB_DATA (NB_DATA)
  ) u_ext (
    .data   (ld_data),
    .size   (size_q),
    .uns    (uns_q),
    .result (ext)
  );

  // request FSM with registered memory and response outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      we_q               <= 1'b0;
      uns_q              <= 1'b0;
      size_q             <= WORD;
      bus.o_rsp_valid    <= 1'b0;
      bus.o_rsp_rdata    <= '0;
      bus.o_rsp_err      <= 1'b0;
      o_mem_r_en         <= 1'b0;
      o_mem_w_en         <= 1'b0;
      o_mem_r_addr       <= '0;
      o_mem_w_addr       <= '0;
      o_mem_r_addressing <= WORD;
      o_mem_w_addressing <= WORD;
      o_mem_w_data       <= '0;
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
      split_q <= 1'b0;
      k       <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            we_q   <= bus.i_req_we;
            uns_q  <= bus.i_req_unsigned;
            size_q <= bus.i_req_size;
            if (bad) begin
              state           <= DONE;
              bus.o_rsp_valid <= 1'b1;
              bus.o_rsp_err   <= 1'b1;
              bus.o_rsp_rdata <= '0;
            end else begin
              state              <= ACCESS;
              o_mem_r_en         <= !bus.i_req_we;
              o_mem_w_en         <= bus.i_req_we;
              o_mem_r_addr       <= bus.i_req_addr;
              o_mem_w_addr       <= bus.i_req_addr;
              o_mem_r_addressing <= bus.i_req_size;
              o_mem_w_addressing <= bus.i_req_size;
              if (bus.i_req_we)
                o_mem_w_data <= bus.i_req_wdata;
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
              split_q <= mis;
              k       <= 2'd0;
              addr_q  <= bus.i_req_addr;
              wdata_q <= bus.i_req_wdata;
              asm_q   <= '0;
              if (mis) begin
                o_mem_r_addressing <= BYTE;
                o_mem_w_addressing <= BYTE;
                o_mem_w_data <= {
                  {(NB_DATA_BUS-NB_DATA){1'b0}},
                  bus.i_req_wdata[NB_DATA-1:0]};
              end
`endif
            end
          end
        end
        ACCESS: begin
          if (last) begin
            state           <= DONE;
            o_mem_r_en      <= 1'b0;
            o_mem_w_en      <= 1'b0;
            bus.o_rsp_valid <= 1'b1;
            bus.o_rsp_err   <= 1'b0;
            bus.o_rsp_rdata <= we_q ? '0 : ext;
          end
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
          else begin
            k      <= kn;
            asm_q  <= asm_nx;
            o_mem_r_addr <= addr_q + NB_ADDRESS'(kn);
            o_mem_w_addr <= addr_q + NB_ADDRESS'(kn);
            o_mem_w_data <= {
              {(NB_DATA_BUS-NB_DATA){1'b0}},
              wdata_q[{kn, 3'b000} +: NB_DATA]};
          end
`endif
        end
        DONE: begin
          state           <= IDLE;
          bus.o_rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte memory model.
// Honours MEM_ACCESS_UNALIGNED_SPLIT_EN for the misaligned case.
module tb_mem_access_unit;

  localparam logic [1:0] SW = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SX = 2'b10;
  localparam logic [1:0] SB = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  r_addr;
  logic        r_en;
  logic [1:0]  r_mode;
  logic [31:0] r_data;
  logic [5:0]  w_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic [1:0]  w_mode;
  logic [7:0]  mem [64];

  int   checks = 0;
  int   errors = 0;
  int   cnt = 0;
  int   acc_cnt = 0;
  bit   r_seen = 0;
  bit   w_seen = 0;
  exp_t exp_q[$];
  int   acc_q[$];

  mem_access_unit_if #(
    .NB_DATA_BUS (32),
    .NB_ADDRESS  (6)
  ) bus ();

  mem_access_unit #(
    .NB_DATA_BUS (32),
    .NB_DATA     (8),
    .N_ADDRESS   (64)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .bus                (bus),
    .o_mem_r_addr       (r_addr),
    .o_mem_r_en         (r_en),
    .o_mem_r_addressing (r_mode),
    .i_mem_r_data       (r_data),
    .o_mem_w_addr       (w_addr),
    .o_mem_w_data       (w_data),
    .o_mem_w_en         (w_en),
    .o_mem_w_addressing (w_mode)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  // asynchronous read port of the byte memory
  always_comb begin
    r_data = 32'h0;
    if (r_en) begin
      case (r_mode)
        SW: r_data = {mem[r_addr + 6'd3],
                      mem[r_addr + 6'd2],
                      mem[r_addr + 6'd1],
                      mem[r_addr]};
        SH: r_data = {16'h0,
                      mem[r_addr + 6'd1],
                      mem[r_addr]};
        SB: r_data = {24'h0, mem[r_addr]};
        default: r_data = 32'h0;
      endcase
    end
  end

  // synchronous write port
  always @(posedge clk) begin
    if (w_en) begin
      case (w_mode)
        SW: begin
          mem[w_addr]        <= w_data[7:0];
          mem[w_addr + 6'd1] <= w_data[15:8];
          mem[w_addr + 6'd2] <= w_data[23:16];
          mem[w_addr + 6'd3] <= w_data[31:24];
        end
        SH: begin
          mem[w_addr]        <= w_data[7:0];
          mem[w_addr + 6'd1] <= w_data[15:8];
        end
        SB: mem[w_addr] <= w_data[7:0];
        default: ;
      endcase
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // response monitor and scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
    end else begin
      r_seen = r_seen | r_en;
      w_seen = w_seen | w_en;
      if (bus.o_rsp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none");
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rsp_rdata", bus.o_rsp_rdata, e.rdata);
          check("rsp_err", 32'(bus.o_rsp_err), 32'(e.err));
          check("rsp_latency", 32'(cnt - a), 32'(e.lat));
        end
      end
      if (bus.i_req_valid && bus.o_req_ready)
        acc_q.push_back(cnt);
    end
  end

  task automatic issue(input logic we,
                       input logic [1:0] size,
                       input logic uns,
                       input logic [5:0] addr,
                       input logic [31:0] wd,
                       input logic [31:0] erd,
                       input logic eerr,
                       input int elat,
                       input bit want);
    int n;
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = we;
    bus.i_req_size     = size;
    bus.i_req_unsigned = uns;
    bus.i_req_addr     = addr;
    bus.i_req_wdata    = wd;
    n = 0;
    @(negedge clk);
    while (!bus.o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected 1");
    end
    acc_cnt = cnt;
    if (want) exp_q.push_back('{erd, eerr, elat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    int n;
    rst_n = 0;
    bus.i_req_valid    = 0;
    bus.i_req_we       = 0;
    bus.i_req_size     = SW;
    bus.i_req_unsigned = 0;
    bus.i_req_addr     = 0;
    bus.i_req_wdata    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    check("rst_ready", 32'(bus.o_req_ready), 1);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 0);
    check("rst_rsp_rdata", bus.o_rsp_rdata, 0);
    check("rst_rsp_err", 32'(bus.o_rsp_err), 0);
    check("rst_en", {30'h0, r_en, w_en}, 0);
    check("rst_addr", {20'h0, r_addr, w_addr}, 0);
    check("rst_mode", {28'h0, r_mode, w_mode}, 0);
    check("rst_wdata", w_data, 0);
    @(posedge clk);
    #1;

    issue(1, SW, 0, 6'h08, 32'hDEADBEEF, 0, 0, 2, 1);
    idle();
    check("mem08", 32'(mem[8]), 32'hEF);
    check("mem09", 32'(mem[9]), 32'hBE);
    check("mem0a", 32'(mem[10]), 32'hAD);
    check("mem0b", 32'(mem[11]), 32'hDE);
    issue(0, SW, 0, 6'h08, 0, 32'hDEADBEEF, 0, 2, 1);
    idle();
    issue(1, SB, 0, 6'h0C, 32'h11, 0, 0, 2, 1);
    idle();
    issue(0, SB, 0, 6'h0B, 0, 32'hFFFFFFDE, 0, 2, 1);
    idle();
    issue(0, SB, 1, 6'h0B, 0, 32'h000000DE, 0, 2, 1);
    idle();
    issue(0, SH, 0, 6'h0A, 0, 32'hFFFFDEAD, 0, 2, 1);
    idle();
    issue(0, SH, 1, 6'h0A, 0, 32'h0000DEAD, 0, 2, 1);
    idle();

    r_seen = 0;
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
    issue(0, SW, 0, 6'h09, 0, 32'h11DEADBE, 0, 5, 1);
    repeat (6) idle();
`else
    issue(0, SW, 0, 6'h09, 0, 0, 1, 1, 1);
    repeat (3) idle();
    check("mis_r_en_seen", 32'(r_seen), 0);
`endif

    issue(1, SB, 0, 6'h10, 32'h77, 0, 0, 2, 1);
    idle();
    w_seen = 0;
    issue(1, SX, 0, 6'h10, 32'hFF, 0, 1, 1, 1);
    repeat (3) idle();
    check("ill_w_en_seen", 32'(w_seen), 0);
    check("ill_mem10", 32'(mem[16]), 32'h77);

    issue(0, SW, 0, 6'h08, 0, 32'hDEADBEEF, 0, 2, 1);
    a0 = acc_cnt;
    issue(0, SB, 1, 6'h08, 0, 32'h000000EF, 0, 2, 1);
    check("b2b_gap1", 32'(acc_cnt - a0), 3);
    a0 = acc_cnt;
    issue(0, SH, 0, 6'h08, 0, 32'hFFFFBEEF, 0, 2, 1);
    check("b2b_gap2", 32'(acc_cnt - a0), 3);
    check("b2b_ready_access", 32'(bus.o_req_ready), 0);
    idle();
    check("b2b_ready_done", 32'(bus.o_req_ready), 0);
    repeat (2) idle();

    issue(1, SB, 0, 6'h20, 32'h5A, 0, 0, 2, 1);
    idle();
    issue(1, SB, 0, 6'h20, 32'hA5, 0, 0, 2, 0);
    bus.i_req_valid = 0;
    check("abort_w_en_pre", 32'(w_en), 1);
    rst_n = 0;
    #1;
    check("abort_w_en", 32'(w_en), 0);
    check("abort_rsp_valid", 32'(bus.o_rsp_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    check("abort_ready", 32'(bus.o_req_ready), 1);
    repeat (4) idle();
    check("abort_mem20", 32'(mem[32]), 32'h5A);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d pending expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
